// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-master register-bus arbiter: FSM states,
// master indices and the idle grant value.
package bus_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arb_rr.sv
// Combinational two-way round-robin pick; a held lock restricts the choice
// to the lock owner.
module bus_arb_rr
    import bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = GRANT_NONE;
        if (lock_valid) begin
            if (req[lock_owner]) grant = onehot(lock_owner);
        end else if (req == 2'b11) begin
            grant = onehot(~last);
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master arbiter for a basil-style register bus: IDLE/ADDR/DATA/DONE
// sequencing, round-robin fairness, optional lock with an idle watchdog.
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int DBUSWIDTH = 8,
    parameter int LOCK_MAX  = 256
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic                 M0_REQ,
    input  logic                 M1_REQ,
    input  logic                 M0_WE,
    input  logic                 M1_WE,
    input  logic                 M0_LOCK,
    input  logic                 M1_LOCK,
    input  logic [ABUSWIDTH-1:0] M0_ADD,
    input  logic [ABUSWIDTH-1:0] M1_ADD,
    input  logic [DBUSWIDTH-1:0] M0_WDATA,
    input  logic [DBUSWIDTH-1:0] M1_WDATA,
    output logic                 M0_ACK,
    output logic                 M1_ACK,
    output logic [DBUSWIDTH-1:0] M_RDATA,
    output logic [1:0]           GRANT,
    output logic                 LOCK_ERR,
    output logic [ABUSWIDTH-1:0] BUS_ADD,
    output logic                 BUS_RD,
    output logic                 BUS_WR,
    output logic [DBUSWIDTH-1:0] BUS_DATA_OUT,
    output logic                 BUS_DATA_OE,
    input  logic [DBUSWIDTH-1:0] BUS_DATA_IN
);

    localparam int WD_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

    logic [1:0]           state;
    logic [1:0]           req_vec;
    logic [1:0]           pick;
    logic                 last;
    logic                 lock_valid;
    logic                 lock_owner;
    logic                 owner_req;
    logic                 wd_hit;
    logic                 cur;
    logic                 cur_we;
    logic                 cur_lock;
    logic [WD_W-1:0]      wdog;
    logic [1:0]           grant_r;
    logic [1:0]           ack_r;
    logic [ABUSWIDTH-1:0] add_r;
    logic [DBUSWIDTH-1:0] data_out_r;
    logic [DBUSWIDTH-1:0] rdata_r;
    logic                 rd_r;
    logic                 wr_r;
    logic                 lock_err_r;
    logic                 win_m1;

    assign req_vec   = {M1_REQ, M0_REQ};
    assign win_m1    = pick[1];
    assign owner_req = req_vec[lock_owner];
    assign wd_hit    = (LOCK_MAX != 0) && (wdog == WD_W'(LOCK_MAX - 1));

    bus_arb_rr u_rr (
        .req        (req_vec),
        .last       (last),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .grant      (pick)
    );

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state      <= ST_IDLE;
            // NOTE: "last served" starts at M1 so a contested first request goes to M0.
            last       <= M1;
            lock_valid <= 1'b0;
            lock_owner <= M0;
            cur        <= M0;
            cur_we     <= 1'b0;
            cur_lock   <= 1'b0;
            wdog       <= '0;
            grant_r    <= GRANT_NONE;
            ack_r      <= GRANT_NONE;
            add_r      <= '0;
            data_out_r <= '0;
            rdata_r    <= '0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            lock_err_r <= 1'b0;
        end else begin
            // NOTE: strobes and ACK default low each cycle, so a set in one state is a one-cycle pulse.
            rd_r  <= 1'b0;
            wr_r  <= 1'b0;
            ack_r <= GRANT_NONE;
            case (state)
                ST_IDLE: begin
                    if (pick != GRANT_NONE) begin
                        cur        <= win_m1;
                        cur_we     <= win_m1 ? M1_WE : M0_WE;
                        cur_lock   <= win_m1 ? M1_LOCK : M0_LOCK;
                        add_r      <= win_m1 ? M1_ADD : M0_ADD;
                        data_out_r <= win_m1 ? M1_WDATA : M0_WDATA;
                        rd_r       <= ~(win_m1 ? M1_WE : M0_WE);
                        wr_r       <= win_m1 ? M1_WE : M0_WE;
                        grant_r    <= pick;
                        state      <= ST_ADDR;
                    end
                    if (lock_valid && !owner_req) begin
                        if (wd_hit) begin
                            lock_valid <= 1'b0;
                            grant_r    <= GRANT_NONE;
                            lock_err_r <= 1'b1;
                            wdog       <= '0;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end else begin
                        wdog <= '0;
                    end
                end
                ST_ADDR: state <= ST_DATA;
                ST_DATA: begin
                    if (!cur_we) rdata_r <= BUS_DATA_IN;
                    ack_r <= onehot(cur);
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    last       <= cur;
                    lock_valid <= cur_lock;
                    lock_owner <= cur;
                    wdog       <= '0;
                    if (!cur_lock) grant_r <= GRANT_NONE;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign M0_ACK       = ack_r[0];
    assign M1_ACK       = ack_r[1];
    assign M_RDATA      = rdata_r;
    assign GRANT        = grant_r;
    assign LOCK_ERR     = lock_err_r;
    assign BUS_ADD      = add_r;
    assign BUS_RD       = rd_r;
    assign BUS_WR       = wr_r;
    assign BUS_DATA_OUT = data_out_r;
    assign BUS_DATA_OE  = wr_r;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: vector table of single transactions,
// scoreboarded bus/ACK monitor, and hand-written lock, watchdog and reset sequences.
module tb_bus_arbiter_2m;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LM = 8;

    typedef struct {
        logic          m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic          m0_lock = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0] m0_add = '0, m1_add = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m_rdata;
    logic [1:0]    grant;
    logic          lock_err;
    logic [AW-1:0] bus_add;
    logic          bus_rd, bus_wr;
    logic [DW-1:0] bus_data_out;
    logic          bus_data_oe;
    logic [DW-1:0] bus_data_in = '0;

    txn_t          bus_q[$];
    txn_t          ack_q[$];
    txn_t          vecs[6];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_rdata = '0;
    logic          prev_strobe = 1'b0;
    int            lat, lat0, lat1;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.ABUSWIDTH(AW), .DBUSWIDTH(DW), .LOCK_MAX(LM)) dut (
        .BUS_CLK      (clk),
        .BUS_RST_N    (rst_n),
        .M0_REQ       (m0_req),
        .M1_REQ       (m1_req),
        .M0_WE        (m0_we),
        .M1_WE        (m1_we),
        .M0_LOCK      (m0_lock),
        .M1_LOCK      (m1_lock),
        .M0_ADD       (m0_add),
        .M1_ADD       (m1_add),
        .M0_WDATA     (m0_wdata),
        .M1_WDATA     (m1_wdata),
        .M0_ACK       (m0_ack),
        .M1_ACK       (m1_ack),
        .M_RDATA      (m_rdata),
        .GRANT        (grant),
        .LOCK_ERR     (lock_err),
        .BUS_ADD      (bus_add),
        .BUS_RD       (bus_rd),
        .BUS_WR       (bus_wr),
        .BUS_DATA_OUT (bus_data_out),
        .BUS_DATA_OE  (bus_data_oe),
        .BUS_DATA_IN  (bus_data_in)
    );

    function automatic logic [DW-1:0] slave_fn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hF5;
    endfunction

    // Slave answers the cycle after BUS_RD and drives zero otherwise.
    always @(posedge clk) bus_data_in <= bus_rd ? slave_fn(bus_add) : 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic m, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input bit want_ack);
        txn_t t;
        t = '{m, we, a, wd, rd};
        bus_q.push_back(t);
        if (want_ack) ack_q.push_back(t);
        model_rdata = rd;
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic we, input logic [AW-1:0] a);
        return we ? model_rdata : slave_fn(a);
    endfunction

    task automatic check_bus();
        txn_t t;
        check("strobe_single_cycle", 64'(prev_strobe), 64'(0));
        check("bus_op_expected", 64'(bus_q.size() != 0), 64'(1));
        if (bus_q.size() != 0) begin
            t = bus_q.pop_front();
            check("bus_op", 64'({bus_add, bus_wr, bus_rd, bus_data_oe, grant}),
                  64'({t.addr, t.we, ~t.we, t.we, (t.m ? 2'b10 : 2'b01)}));
            if (t.we) check("bus_wdata", 64'(bus_data_out), 64'(t.wdata));
        end
    endtask

    task automatic check_ack();
        txn_t t;
        check("ack_expected", 64'(ack_q.size() != 0), 64'(1));
        if (ack_q.size() != 0) begin
            t = ack_q.pop_front();
            check("ack_rdata", 64'({m1_ack, m0_ack, m_rdata}), 64'({t.m, ~t.m, t.rdata}));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe <= 1'b0;
        end else begin
            if (bus_rd || bus_wr) check_bus();
            if (m0_ack || m1_ack) check_ack();
            prev_strobe <= bus_rd | bus_wr;
        end
    end

    task automatic set_master(input logic m, input logic req, input logic we, input logic lock,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (!m) begin
            m0_req = req; m0_we = we; m0_lock = lock; m0_add = a; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_lock = lock; m1_add = a; m1_wdata = wd;
        end
    endtask

    task automatic wait_ack(input logic m, input int max, output int cyc);
        logic a;
        cyc = 0;
        a = 1'b0;
        while (!a && cyc < max) begin
            @(negedge clk);
            cyc++;
            a = m ? m1_ack : m0_ack;
        end
        check(m ? "ack_wait_m1" : "ack_wait_m0", 64'(a), 64'(1));
    endtask

    task automatic wait_grant(input logic [1:0] exp, input int max);
        int n = 0;
        while (grant !== exp && n < max) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", 64'(grant), 64'(exp));
    endtask

    // Holds REQ across n back-to-back transactions, updating LOCK per transaction at each ACK.
    task automatic master_seq(input logic m, input int n, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [7:0] lock_mask, output int first_lat);
        int cyc;
        first_lat = 0;
        for (int k = 0; k < n; k++) begin
            set_master(m, 1'b1, we, lock_mask[k], a, wd);
            wait_ack(m, 200, cyc);
            if (k == 0) first_lat = cyc;
        end
        set_master(m, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h4010, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'hD3};
        vecs[2] = '{1'b0, 1'b1, 16'h0001, 8'h11, 8'hD3};
        vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 8'hD3};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hF5};
        vecs[5] = '{1'b0, 1'b0, 16'hFF00, 8'h00, 8'h0A};

        #12;
        check("reset_bus", 64'({bus_add, bus_rd, bus_wr, bus_data_out, bus_data_oe}), 64'(0));
        check("reset_master", 64'({m0_ack, m1_ack, grant, m_rdata, lock_err}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single transactions from the table: latency, data and idle bus state.
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b1);
            set_master(vecs[i].m, 1'b1, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata);
            wait_ack(vecs[i].m, 20, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
            set_master(vecs[i].m, 1'b0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            check($sformatf("vec%0d_idle_hold", i), 64'({bus_add, grant}), 64'({vecs[i].addr, 2'b00}));
        end

        // Fresh reset, then both masters write continuously: M0 first, then alternate.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 1'b1, 16'h0001, 8'h11, model_rdata, 1'b1);
            push(1'b1, 1'b1, 16'h0002, 8'h22, model_rdata, 1'b1);
        end
        fork
            master_seq(1'b0, 4, 1'b1, 16'h0001, 8'h11, 8'h00, lat0);
            master_seq(1'b1, 4, 1'b1, 16'h0002, 8'h22, 8'h00, lat1);
        join
        check("alt_m0_first_latency", 64'(lat0), 64'(3));
        check("alt_m1_first_latency", 64'(lat1), 64'(7));
        @(negedge clk);

        // M1 holds the lock for three writes; M0 waits until the unlocking write completes.
        for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 16'h0100, 8'h5A, model_rdata, 1'b1);
        push(1'b0, 1'b1, 16'h0200, 8'h33, model_rdata, 1'b1);
        fork
            master_seq(1'b1, 4, 1'b1, 16'h0100, 8'h5A, 8'h07, lat1);
            begin
                wait_grant(2'b10, 20);
                master_seq(1'b0, 1, 1'b1, 16'h0200, 8'h33, 8'h00, lat0);
            end
        join
        check("lock_no_err", 64'(lock_err), 64'(0));
        @(negedge clk);

        // M0 locks then idles; the watchdog frees the bus for M1 after LM idle cycles.
        push(1'b0, 1'b1, 16'h0300, 8'h44, model_rdata, 1'b1);
        master_seq(1'b0, 1, 1'b1, 16'h0300, 8'h44, 8'h01, lat0);
        check("wd_lock_txn_latency", 64'(lat0), 64'(3));
        push(1'b1, 1'b0, 16'h2A55, 8'h00, exp_rd(1'b0, 16'h2A55), 1'b1);
        set_master(1'b1, 1'b1, 1'b0, 1'b0, 16'h2A55, 8'h00);
        for (int i = 1; i <= LM; i++) begin
            @(negedge clk);
            if (i == 1 || i == LM)
                check($sformatf("wd_locked_idle%0d", i), 64'({grant, lock_err}), 64'({2'b01, 1'b0}));
        end
        @(negedge clk);
        check("wd_released", 64'({grant, lock_err}), 64'({2'b00, 1'b1}));
        wait_ack(1'b1, 10, lat);
        check("wd_m1_latency", 64'(lat), 64'(3));
        set_master(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Reset during the ADDR cycle of an M0 write; the pending M1 request completes afterwards.
        push(1'b0, 1'b1, 16'hBEEF, 8'h99, model_rdata, 1'b0);
        set_master(1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF, 8'h99);
        set_master(1'b1, 1'b1, 1'b1, 1'b0, 16'h0BAD, 8'h77);
        @(negedge clk);
        check("rst_pre_wr", 64'(bus_wr), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_strobe", 64'({bus_wr, bus_data_oe, bus_rd}), 64'(0));
        check("rst_mid_state", 64'({grant, m0_ack, m1_ack, lock_err, bus_add}), 64'(0));
        set_master(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        model_rdata = '0;
        push(1'b1, 1'b1, 16'h0BAD, 8'h77, model_rdata, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(1'b1, 10, lat);
        check("rst_m1_latency", 64'(lat), 64'(3));
        set_master(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);

        check("bus_q_drained", 64'(bus_q.size()), 64'(0));
        check("ack_q_drained", 64'(ack_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Shares one basil-style register bus (BUS_ADD / BUS_RD / BUS_WR / data) between two masters.
  - M0: host path, e.g. FX2 bridge via a request adapter.
  - M1: internal sequencer / second host.
- Sequences each transaction as address phase, one-cycle strobe, then read-data capture, and returns an ACK to the winner.
- Provides round-robin fairness and an optional bus lock for atomic sequences, with a lock watchdog.

Parameters:
- ABUSWIDTH, 16, bus address width.
- DBUSWIDTH, 8, bus data width.
- LOCK_MAX, 256, max idle cycles a locking master may hold the grant without requesting; 0 disables the watchdog.

Ports:
- BUS_CLK  in  1  bus clock; all logic on rising edge.
- BUS_RST_N  in  1  asynchronous active-low reset.
- M0_REQ, M1_REQ  in  1  transaction request; held until ACK.
- M0_WE, M1_WE  in  1  1 = write, 0 = read; stable while REQ.
- M0_LOCK, M1_LOCK  in  1  keep grant after this transaction.
- M0_ADD, M1_ADD  in  ABUSWIDTH  address; stable while REQ.
- M0_WDATA, M1_WDATA  in  DBUSWIDTH  write data.
- M0_ACK, M1_ACK  out  1  one-cycle completion pulse.
- M_RDATA  out  DBUSWIDTH  read data; valid with ACK, shared by both masters.
- GRANT  out  2  one-hot current owner; 00 = none.
- LOCK_ERR  out  1  sticky; set on watchdog lock release, cleared only by reset.
- BUS_ADD  out  ABUSWIDTH  bus address.
- BUS_RD, BUS_WR  out  1  one-cycle strobes.
- BUS_DATA_OUT  out  DBUSWIDTH  write data.
- BUS_DATA_OE  out  1  write-data enable for the top-level tristate.
- BUS_DATA_IN  in  DBUSWIDTH  read data; slaves drive it the cycle after BUS_RD.

Behaviour:
- Reset (async, BUS_RST_N=0):
  - All outputs 0: BUS_ADD=0, strobes=0, OE=0, ACK=0, GRANT=00, M_RDATA=0, LOCK_ERR=0.
  - FSM goes to IDLE, round-robin pointer favours M0, lock cleared, watchdog=0.
  - Reset mid-transaction: strobes drop immediately, the transaction is dropped and no ACK is issued.
- FSM states IDLE -> ADDR -> DATA -> DONE -> IDLE.
- IDLE:
  - Evaluate requests. If locked, only the lock owner may win.
  - Otherwise a single requester wins. If both request, the master not granted last wins.
  - On a win, register ADD/WE/WDATA/LOCK of the winner, set GRANT, go to ADDR.
- ADDR (1 cycle):
  - BUS_ADD = latched address.
  - BUS_WR=1 with BUS_DATA_OE=1 and DATA_OUT valid if write; else BUS_RD=1.
- DATA (1 cycle):
  - BUS_ADD held; strobes 0; OE 0.
  - For reads, BUS_DATA_IN is registered into M_RDATA at the end of this cycle.
- DONE (1 cycle):
  - Winner's ACK=1; M_RDATA valid (writes leave M_RDATA unchanged).
  - Pointer updated. Lock owner = winner if latched LOCK=1, else none.
  - Go to IDLE.
- Requester handshake:
  - The requester must deassert REQ or present a new request in the cycle after ACK.
  - A REQ still high in IDLE is a new transaction.
- Timing:
  - Latency from REQ rising (IDLE sampled) to ACK: 3 cycles.
  - Throughput: 1 transaction per 4 cycles.
- BUS_ADD holds its last value in IDLE (no toggling between transactions).
- GRANT stays set from ADDR through DONE, and through IDLE while a lock is held.
- Lock and watchdog:
  - While locked and the owner's REQ=0, the watchdog counts up each IDLE cycle. It resets to 0 on any owner request.
  - Owner dropping LOCK on a later transaction releases the lock at that DONE.
  - When the count reaches LOCK_MAX: release the lock, set LOCK_ERR, arbitrate normally from the next cycle.
- REQ deasserted by a master mid-transaction: ignored; the transaction completes and ACK still pulses.
- Simultaneous REQ from both masters immediately after reset: M0 wins.

Decomposition:
- Package bus_arb_pkg:
  - FSM state encoding (IDLE/ADDR/DATA/DONE).
  - Master index constants M0=0, M1=1.
  - GRANT_NONE=2'b00.
- Sub-module bus_arb_rr: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last, lock_valid, lock_owner.
  - Output: one-hot grant.

Test Plan:
- Single M0 read of 0x4010, slave returns 0xA5 the cycle after BUS_RD -> BUS_RD high exactly 1 cycle, M0_ACK 3 cycles after REQ, M_RDATA=0xA5, GRANT=01 during.
- M0 and M1 both write (0x0001/0x11, 0x0002/0x22) continuously for 4 transactions each -> grants alternate M0, M1, M0, …; each BUS_WR exactly 1 cycle with matching OE/DATA_OUT.
- M1 issues 3 writes with LOCK=1 while M0 requests -> M0 served only after M1's transaction with LOCK=0; LOCK_ERR stays 0.
- LOCK_MAX=8, M0 locks then idles, M1 requests -> lock released after 8 idle cycles, LOCK_ERR=1, M1 ACK follows 3 cycles later.
- Assert BUS_RST_N low during ADDR of a write -> BUS_WR=0 asynchronously, no ACK, GRANT=00; after release, a pending M1 request completes normally.
